accel_accumulator: RTL

- Upstream stage of the timestep FSM that resolves forces.
- Clears and accumulates per-body acceleration (x/y/z, IEEE-754 single) over all ordered body pairs (i≠j) for one timestep. Pair order is i-major, j-minor.
- For each pair it requests the contribution from an external pairwise gravity kernel over a valid/ready handshake, then sums it into body i's accumulator.
- Final accumulators feed the acceleration slots of the datafile consumed by the force-resolve FSM.

---
 rtl/accel_accumulator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/accel_accumulator.sv
// Per-body acceleration accumulator: walks all ordered body pairs (i != j), requests each
// contribution from an external pairwise kernel and sums it into body i's x/y/z accumulators.
module accel_accumulator #(
  parameter int unsigned MAX_BODIES = 10,
  parameter int unsigned IDX_W      = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ACC_START,
  output logic             ACC_DONE,
  input  logic [31:0]      NUM_BODIES,
  output logic             PAIR_VALID,
  input  logic             PAIR_READY,
  output logic [IDX_W-1:0] PAIR_I,
  output logic [IDX_W-1:0] PAIR_J,
  input  logic             RES_VALID,
  input  logic [31:0]      RES_AX,
  input  logic [31:0]      RES_AY,
  input  logic [31:0]      RES_AZ,
  output logic [31:0]      ACC_X [MAX_BODIES],
  output logic [31:0]      ACC_Y [MAX_BODIES],
  output logic [31:0]      ACC_Z [MAX_BODIES]
);

  typedef enum logic [2:0] {StIdle, StClear, StIssue, StWaitRes, StNext, StDone} state_e;

  // IEEE-754 single-precision add, round-to-nearest-even, subnormals supported.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my0, my;
    logic [63:0] shf;
    logic [27:0] m;
    logic [9:0]  e;
    logic [24:0] r;
    logic        up, nan_a, nan_b, inf_a, inf_b;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey  = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx  = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my0 = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d   = ex - ey;
    shf = {my0, 37'd0} >> ((d > 8'd37) ? 8'd37 : d);
    my  = {shf[63:38], shf[37] | (|shf[36:0])};
    e   = {2'b00, ex};
    if (x[31] == y[31]) m = {1'b0, mx} + {1'b0, my};
    else                m = {1'b0, mx} - {1'b0, my};
    if (m[27]) begin
      m = {1'b0, m[27:2], m[1] | m[0]};
      e = e + 10'd1;
    end
    for (int k = 0; k < 26; k++) begin
      if (!m[26] && (e > 10'd1)) begin
        m = m << 1;
        e = e - 10'd1;
      end
    end
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[26:3]} + {24'd0, up};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'd1;
    end
    if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
      res = 32'h7FC00000;
    end else if (inf_a) begin
      res = a;
    end else if (inf_b) begin
      res = b;
    end else if (m == 28'd0) begin
      // Exact cancellation gives +0; only -0 + -0 stays negative.
      res = {(x[31] == y[31]) ? x[31] : 1'b0, 31'd0};
    end else if (e >= 10'd255) begin
      res = {x[31], 8'hFF, 23'd0};
    end else begin
      res = {x[31], r[23] ? e[7:0] : 8'h00, r[22:0]};
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W:0]   j_step, i_step, n_ext;
  logic             clear, acc_en;
  logic [31:0]      sum_x, sum_y, sum_z;
  logic [31:0]      acc_x_q [MAX_BODIES];
  logic [31:0]      acc_y_q [MAX_BODIES];
  logic [31:0]      acc_z_q [MAX_BODIES];

  always_comb begin
    n_ext  = {1'b0, n_q};
    i_step = {1'b0, i_q} + (IDX_W + 1)'(1);
    j_step = (({1'b0, j_q} + (IDX_W + 1)'(1)) == {1'b0, i_q}) ?
             {1'b0, j_q} + (IDX_W + 1)'(2) : {1'b0, j_q} + (IDX_W + 1)'(1);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    clear   = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ACC_START) begin
          n_d     = (NUM_BODIES > 32'(MAX_BODIES)) ? IDX_W'(MAX_BODIES) : NUM_BODIES[IDX_W-1:0];
          state_d = StClear;
        end
      end
      StClear: begin
        clear   = 1'b1;
        i_d     = '0;
        j_d     = IDX_W'(1);
        state_d = (n_q < IDX_W'(2)) ? StDone : StIssue;
      end
      StIssue: begin
        if (PAIR_READY) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (RES_VALID) begin
          acc_en  = 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        if (j_step >= n_ext) begin
          // After a row wrap i >= 1, so j restarts at 0 without colliding with i.
          i_d     = i_step[IDX_W-1:0];
          j_d     = '0;
          state_d = (i_step >= n_ext) ? StDone : StIssue;
        end else begin
          j_d     = j_step[IDX_W-1:0];
          state_d = StIssue;
        end
      end
      StDone: begin
        if (!ACC_START) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    sum_x = fp_add(acc_x_q[i_q], RES_AX);
    sum_y = fp_add(acc_y_q[i_q], RES_AY);
    sum_z = fp_add(acc_z_q[i_q], RES_AZ);
  end

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      for (int k = 0; k < int'(MAX_BODIES); k++) begin
        acc_x_q[k] <= 32'd0;
        acc_y_q[k] <= 32'd0;
        acc_z_q[k] <= 32'd0;
      end
    end else if (acc_en) begin
      acc_x_q[i_q] <= sum_x;
      acc_y_q[i_q] <= sum_y;
      acc_z_q[i_q] <= sum_z;
    end
  end

  assign ACC_X      = acc_x_q;
  assign ACC_Y      = acc_y_q;
  assign ACC_Z      = acc_z_q;
  assign PAIR_VALID = (state_q == StIssue);
  assign ACC_DONE   = (state_q == StDone);
  assign PAIR_I     = i_q;
  assign PAIR_J     = j_q;

endmodule
